// File: rtl/cc_var_delay.sv
// cc_var_delay
//   Clock-enabled delay line with MAX_DELAY register stages, each carrying a
//   valid bit next to its data word. The output tap is chosen at runtime, so
//   one instance covers every latency from 0 (pure passthrough) to MAX_DELAY.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous active-high clear of every stage and of fill
//   en         advance enable; the line shifts only when en=1
//   flush      synchronous clear of every stage and of fill; beats en
//   delay_sel  requested latency; values above MAX_DELAY clamp to MAX_DELAY
//   in         data word entering stage 0
//   in_valid   qualifier for in
//   out        data at the selected tap (in itself when the delay is 0)
//   out_valid  valid bit at the selected tap (in_valid when the delay is 0)
//   fill       enabled shifts since reset/flush, saturating at MAX_DELAY
//   primed     1 when fill has reached the effective delay
module cc_var_delay #(
  parameter int WIDTH     = 8,
  parameter int MAX_DELAY = 8,
  localparam int SEL_W    = $clog2(MAX_DELAY + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             flush,
  input  logic [SEL_W-1:0] delay_sel,
  input  logic [WIDTH-1:0] in,
  input  logic             in_valid,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  output logic [SEL_W-1:0] fill,
  output logic             primed
);

  logic [WIDTH-1:0]     data_q  [MAX_DELAY];
  logic [WIDTH-1:0]     data_d  [MAX_DELAY];
  logic [MAX_DELAY-1:0] valid_q;
  logic [MAX_DELAY-1:0] valid_d;
  logic [SEL_W-1:0]     fill_q;
  logic [SEL_W-1:0]     fill_d;
  logic [SEL_W-1:0]     eff_delay;

  // Clamp the requested latency so the tap mux can never address past the last stage.
  always_comb begin
    if (delay_sel > SEL_W'(MAX_DELAY)) begin
      eff_delay = SEL_W'(MAX_DELAY);
    end else begin
      eff_delay = delay_sel;
    end
  end

  // Next state of the line: flush clears, en shifts, otherwise everything holds.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    fill_d  = fill_q;
    if (flush) begin
      for (int i = 0; i < MAX_DELAY; i++) begin
        data_d[i] = {WIDTH{1'b0}};
      end
      valid_d = {MAX_DELAY{1'b0}};
      fill_d  = {SEL_W{1'b0}};
    end else if (en) begin
      // Invalid samples still move through the line; only their tag says so.
      data_d[0]  = in;
      valid_d[0] = in_valid;
      for (int i = 1; i < MAX_DELAY; i++) begin
        data_d[i]  = data_q[i-1];
        valid_d[i] = valid_q[i-1];
      end
      if (fill_q != SEL_W'(MAX_DELAY)) begin
        fill_d = fill_q + SEL_W'(1);
      end else begin
        fill_d = fill_q;
      end
    end else begin
      data_d  = data_q;
      valid_d = valid_q;
      fill_d  = fill_q;
    end
  end

  // Stage storage and fill counter; reset clears them without waiting for clk.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < MAX_DELAY; i++) begin
        data_q[i] <= {WIDTH{1'b0}};
      end
      valid_q <= {MAX_DELAY{1'b0}};
      fill_q  <= {SEL_W{1'b0}};
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      fill_q  <= fill_d;
    end
  end

  // Tap mux: delay 0 passes the input straight through, delay k reads stage k-1.
  // The tap follows delay_sel in the same cycle; stage valid bits keep out_valid honest.
  always_comb begin
    out       = in;
    out_valid = in_valid;
    for (int i = 0; i < MAX_DELAY; i++) begin
      out       = (eff_delay == SEL_W'(i + 1)) ? data_q[i]  : out;
      out_valid = (eff_delay == SEL_W'(i + 1)) ? valid_q[i] : out_valid;
    end
  end

  // Status outputs; primed is trivially 1 for delay 0 since fill >= 0.
  always_comb begin
    fill   = fill_q;
    primed = (fill_q >= eff_delay);
  end

endmodule

// File: tb/tb_cc_var_delay.sv
// Testbench for cc_var_delay. Two instances (MAX_DELAY=8 and MAX_DELAY=5) share
// one stimulus stream. A reference model keeps, per instance, the history of
// enabled samples (newest first) since the last reset/flush; the expected tap
// for latency d is simply the (d-1)-th newest sample, or {0,0} if the line has
// not shifted that far yet. Expected responses are queued by the stimulus
// process and popped by an independent monitor.
module tb_cc_var_delay;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic       flush;
  logic [3:0] sel;
  logic [7:0] din;
  logic       vin;

  logic [7:0] out_a;
  logic       ov_a;
  logic [3:0] fill_a;
  logic       pr_a;
  logic [7:0] out_b;
  logic       ov_b;
  logic [2:0] fill_b;
  logic       pr_b;

  always #5 clk = ~clk;

  cc_var_delay #(.WIDTH(8), .MAX_DELAY(8)) dut_a (
    .clk(clk), .reset(reset), .en(en), .flush(flush), .delay_sel(sel),
    .in(din), .in_valid(vin), .out(out_a), .out_valid(ov_a),
    .fill(fill_a), .primed(pr_a)
  );

  cc_var_delay #(.WIDTH(8), .MAX_DELAY(5)) dut_b (
    .clk(clk), .reset(reset), .en(en), .flush(flush), .delay_sel(sel[2:0]),
    .in(din), .in_valid(vin), .out(out_b), .out_valid(ov_b),
    .fill(fill_b), .primed(pr_b)
  );

  typedef struct packed {
    logic [7:0] data;
    logic       valid;
    logic [3:0] fill;
    logic       primed;
  } exp_t;

  exp_t       exp_q [2][$];
  logic [8:0] hist  [2][$];   // {valid, data}, index 0 = newest enabled sample
  int         fillc [2];
  int         maxd  [2] = '{8, 5};
  int         vectors     = 0;
  int         miscompares = 0;

  task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s (dut %0d) at %0t: got %0h expected %0h", name, k, $time, act, expv);
    end
  endtask

  task automatic clear_model(input int k);
    hist[k].delete();
    fillc[k] = 0;
  endtask

  function automatic exp_t predict(input int k);
    exp_t e;
    int   s;
    int   d;
    s = (k == 0) ? int'(sel) : int'(sel[2:0]);
    d = (s > maxd[k]) ? maxd[k] : s;
    if (d == 0) begin
      e.data  = din;
      e.valid = vin;
    end else if (d - 1 < hist[k].size()) begin
      e.data  = hist[k][d-1][7:0];
      e.valid = hist[k][d-1][8];
    end else begin
      e.data  = 8'h00;
      e.valid = 1'b0;
    end
    e.fill   = 4'(fillc[k]);
    e.primed = (fillc[k] >= d);
    return e;
  endfunction

  // One clock cycle: drive at negedge, queue expectations, advance model at posedge.
  task automatic cycle(input logic r, input logic e, input logic f,
                       input logic [3:0] s, input logic [7:0] dv, input logic v);
    @(negedge clk);
    reset = r; en = e; flush = f; sel = s; din = dv; vin = v;
    if (r) begin
      for (int k = 0; k < 2; k++) clear_model(k);
    end
    #1;
    for (int k = 0; k < 2; k++) exp_q[k].push_back(predict(k));
    @(posedge clk);
    if (!r) begin
      for (int k = 0; k < 2; k++) begin
        if (f) begin
          clear_model(k);
        end else if (e) begin
          hist[k].push_front({v, dv});
          if (hist[k].size() > maxd[k]) void'(hist[k].pop_back());
          if (fillc[k] < maxd[k]) fillc[k]++;
        end
      end
    end
  endtask

  // Monitor: sample both instances mid-cycle and compare with the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      for (int k = 0; k < 2; k++) begin
        if (exp_q[k].size() > 0) begin
          e = exp_q[k].pop_front();
          check("out",       k, (k == 0) ? {24'd0, out_a} : {24'd0, out_b},        {24'd0, e.data});
          check("out_valid", k, (k == 0) ? {31'd0, ov_a}  : {31'd0, ov_b},         {31'd0, e.valid});
          check("fill",      k, (k == 0) ? {28'd0, fill_a} : {29'd0, fill_b},      {28'd0, e.fill});
          check("primed",    k, (k == 0) ? {31'd0, pr_a}  : {31'd0, pr_b},         {31'd0, e.primed});
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; en = 1'b0; flush = 1'b0; sel = 4'd0; din = 8'h00; vin = 1'b0;
    for (int k = 0; k < 2; k++) clear_model(k);

    // Reset state.
    cycle(1'b1, 1'b0, 1'b0, 4'd3, 8'h00, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 4'd3, 8'h12, 1'b1);

    // Fixed latency 3, counting data, fill runs into saturation.
    for (int i = 1; i <= 12; i++) cycle(1'b0, 1'b1, 1'b0, 4'd3, 8'(i), 1'b1);

    // Reset asserted mid-stream; checked before the next rising edge.
    cycle(1'b1, 1'b1, 1'b0, 4'd3, 8'h77, 1'b1);

    // Stall pattern with latency 2.
    cycle(1'b0, 1'b1, 1'b0, 4'd2, 8'hA5, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 4'd2, 8'h11, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 4'd2, 8'h22, 1'b1);
    cycle(1'b0, 1'b1, 1'b0, 4'd2, 8'h33, 1'b1);
    cycle(1'b0, 1'b1, 1'b0, 4'd2, 8'h44, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 4'd2, 8'h55, 1'b0);

    // Passthrough and clamping of out-of-range selections.
    cycle(1'b0, 1'b1, 1'b0, 4'd0,  8'h3C, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 4'd7,  8'h00, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 4'd15, 8'h00, 1'b0);

    // Fill with valid data, then flush together with en and 0xFF; sweep every tap.
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 1'b0, 4'd8, 8'(8'h10 + i), 1'b1);
    cycle(1'b0, 1'b1, 1'b1, 4'd3, 8'hFF, 1'b1);
    for (int s = 0; s < 16; s++) cycle(1'b0, 1'b0, 1'b0, 4'(s), 8'h5A, 1'b0);

    // Tap changes on a steady stream.
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, 1'b0, 4'd4, 8'(8'h60 + i), 1'b1);
    cycle(1'b0, 1'b1, 1'b0, 4'd1, 8'h66, 1'b1);
    cycle(1'b0, 1'b1, 1'b1, 4'd1, 8'h67, 1'b1);
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 1'b0, 4'd6, 8'(8'h80 + i), 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 2000; i++) begin
      cycle(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 15) == 0), 4'($urandom_range(0, 15)),
            8'($urandom), 1'($urandom));
    end

    @(negedge clk);
    #3;
    check("drain", 0, 32'(exp_q[0].size()), 32'd0);
    check("drain", 1, 32'(exp_q[1].size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
